rip_axi_arbiter: RTL and testbench
==================================

Name: rip_axi_arbiter

Overview:
- Shares one rip_axi_master user port between N_PORTS requesters, e.g. instruction fetch (port 0) and data load/store (port 1).
- Read and write channels are arbitrated independently, each with its own round-robin arbiter and one transaction in flight per channel.
- Requester-side handshake mirrors the rip_axi_master user interface (ready / valid-pulse / done-pulse), so a requester cannot tell whether it is connected directly or through the arbiter.

Parameters:
- N_PORTS, 2, number of requesters (2..4).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, AXI beat width.
- BURST_LEN, 2, beats per transaction; line width is L = DATA_WIDTH*BURST_LEN.
- B_WIDTH, 8, bits per strobe lane; strobe width is S = L/B_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_wready  out  N_PORTS  requester i may pulse s_wvalid[i].
- s_waddr  in  N_PORTS*ADDR_WIDTH  write address, slice i belongs to port i.
- s_wdata  in  N_PORTS*L  write data.
- s_wstrb  in  N_PORTS*S  byte strobes.
- s_wvalid  in  N_PORTS  one-cycle write request pulse.
- s_wdone  out  N_PORTS  one-cycle write completion pulse.
- s_rready  out  N_PORTS  requester i may pulse s_rvalid[i].
- s_raddr  in  N_PORTS*ADDR_WIDTH  read address.
- s_rvalid  in  N_PORTS  one-cycle read request pulse.
- s_rdata  out  L  read data, shared bus, valid when any s_rdone bit is set.
- s_rdone  out  N_PORTS  one-cycle read completion pulse.
- m_wready  in  1  from master wready.
- m_waddr  out  ADDR_WIDTH  to master waddr.
- m_wdata  out  L  to master wdata.
- m_wstrb  out  S  to master wstrb.
- m_wvalid  out  1  to master wvalid.
- m_wdone  in  1  from master wdone.
- m_rready  in  1  from master rready.
- m_raddr  out  ADDR_WIDTH  to master raddr.
- m_rvalid  out  1  to master rvalid.
- m_rdata  in  L  from master rdata.
- m_rdone  in  1  from master rdone.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Read and write channels are identical and fully independent; a read and a write may be in flight at the same time. The read channel is described below; the write channel is the same with w in place of r, plus wdata and wstrb.
- Request capture:
  - s_rvalid[i] && s_rready[i] at an edge sets pend[i] and latches addr[i].
  - s_rvalid[i] while s_rready[i]=0 is ignored.
- s_rready[i] is combinational: !pend[i] && !(busy && gnt==i).
- FSM per channel: IDLE, ISSUE, WAIT.
  - IDLE: if any pend and m_rready, choose the winner by round-robin starting at last+1 mod N_PORTS. At the edge: gnt<=winner, m_raddr<=addr[winner], m_rvalid<=1, busy<=1, go to ISSUE.
  - ISSUE: m_rvalid<=0; go to WAIT. m_rvalid is exactly one cycle wide.
  - WAIT: on m_rdone: s_rdata<=m_rdata, s_rdone[gnt]<=1 for one cycle, pend[gnt]<=0, busy<=0, last<=gnt, go to IDLE.
  - m_rdone seen outside WAIT is ignored.
- s_rdata holds its value until the next completion.
- Latency, uncontended, master idle:
  - request at edge T → m_rvalid high in cycle T+2;
  - m_rdone at edge D → s_rdone high in cycle D+1.
- Done-cycle ready: pend[gnt] clears on the same edge that raises s_rdone, so s_rready[gnt] is high in the cycle s_rdone is high, and a back-to-back request issued in that cycle is accepted.
- Simultaneous requests from several ports in one cycle are all captured. They are served in round-robin order, one per FSM round trip.
- A newly captured request is not visible to the IDLE decision until the following cycle (no bypass).
- Reset mid-transaction:
  - FSM returns to IDLE; pend, busy and gnt clear; last resets to N_PORTS-1 so port 0 wins first.
  - Any in-flight transaction is dropped without a done pulse. The master is reset by the same reset.
- Reset values:
  - m_rvalid, m_wvalid, s_rdone, s_wdone: 0.
  - m_raddr, m_waddr, m_wdata, m_wstrb, s_rdata: 0.
  - s_rready, s_wready: all ones.
- Port indexing: slice i of every flat bus is bits [(i+1)*W-1 : i*W].

Test Plan:
1. Single read: port 0 writes 0x1234 to 0x10, then port 0 reads 0x10 → m_rvalid pulses once with m_raddr=0x10; s_rdone=01; s_rdata=0x0000000000001234; s_rdone[1] never asserts.
2. Simultaneous reads: port 0 reads 0x10 and port 1 reads 0x18 in the same cycle, after writes of 0x1234567890abcdef and 0xcdef90ab56781234 → port 0 completes first with 0x1234567890abcdef, then port 1 with 0xcdef90ab56781234; exactly two m_rvalid pulses.
3. Fairness: both ports continuously re-request reads (4 each) using the done-cycle ready → grant order 0,1,0,1,0,1,0,1; no port is granted twice in a row while the other is pending.
4. Concurrency: port 1 writes 0x000000000fab1e55 to 0x38 in the same cycle port 0 reads 0x30 (holding 0xc0ffeeadd1c0ffee) → m_wvalid and m_rvalid both pulse and the transactions overlap; port 0 gets 0xc0ffeeadd1c0ffee; a later read of 0x38 returns 0x000000000fab1e55.
5. Strobes: port 1 fills 0x20 with 0xcafecafecafecafe, then writes 0xbeefbeefbeefbeef with strb 0b01100100 → m_wstrb=0b01100100 is passed through; a read of 0x20 returns 0xcaefbefecaefcafe.
6. Reset in WAIT: assert rst for 1 cycle while a port 1 read is in flight → next cycle all outputs are at their reset values and s_rready=11; after the master recovers, a port 0 read of 0x10 completes normally with s_rdone=01.

Source files
------------

// File: rtl/rip_axi_arbiter.sv
// rip_axi_arbiter: round-robin sharing of one rip_axi_master user port, independent read and write channels
module rip_axi_arbiter_chan #(
   parameter int N = 2,
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   output logic [N-1:0]   s_ready,
   input  logic [N*W-1:0] s_pay,
   input  logic [N-1:0]   s_valid,
   output logic [N-1:0]   s_done,
   input  logic           m_ready,
   output logic [W-1:0]   m_pay,
   output logic           m_valid,
   input  logic           m_done,
   output logic           fin
);
   localparam int GW = N > 1 ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_nxt;
   logic [N-1:0] pend;
   logic [W-1:0] pay [N];
   logic [GW-1:0] gnt, last, win;
   logic busy, go;
   assign busy = state != IDLE;
   assign go = state == IDLE && |pend && m_ready;
   assign fin = state == WAIT && m_done;
   // scan downward so the nearest pending port after last overwrites the rest
   always_comb begin
      win = last;
      for (int k = N; k >= 1; k--)
         if (pend[GW'((int'(last) + k) % N)]) win = GW'((int'(last) + k) % N);
   end
   always_comb state_nxt = go ? ISSUE : state == ISSUE ? WAIT : fin ? IDLE : state;
   for (genvar i = 0; i < N; i++) begin : g_rdy
      assign s_ready[i] = !pend[i] && !(busy && gnt == GW'(i));
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk) begin
      if (rst) begin
         pend    <= '0;
         gnt     <= '0;
         last    <= GW'(N - 1);
         m_valid <= 1'b0;
         m_pay   <= '0;
         s_done  <= '0;
      end else begin
         pend    <= (pend | (s_valid & s_ready)) & ~(fin ? N'(1) << gnt : N'(0));
         m_valid <= go;
         s_done  <= fin ? N'(1) << gnt : N'(0);
         if (go) begin
            gnt   <= win;
            m_pay <= pay[win];
         end
         if (fin) last <= gnt;
      end
   end
   always_ff @(posedge clk)
      for (int i = 0; i < N; i++)
         if (s_valid[i] && s_ready[i]) pay[i] <= s_pay[i*W +: W];
endmodule

module rip_axi_arbiter #(
   parameter int N_PORTS    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 2,
   parameter int B_WIDTH    = 8
) (
   input  logic                                         clk,
   input  logic                                         rst,
   output logic [N_PORTS-1:0]                           s_wready,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]                s_waddr,
   input  logic [N_PORTS*DATA_WIDTH*BURST_LEN-1:0]      s_wdata,
   input  logic [N_PORTS*DATA_WIDTH*BURST_LEN/B_WIDTH-1:0] s_wstrb,
   input  logic [N_PORTS-1:0]                           s_wvalid,
   output logic [N_PORTS-1:0]                           s_wdone,
   output logic [N_PORTS-1:0]                           s_rready,
   input  logic [N_PORTS*ADDR_WIDTH-1:0]                s_raddr,
   input  logic [N_PORTS-1:0]                           s_rvalid,
   output logic [DATA_WIDTH*BURST_LEN-1:0]              s_rdata,
   output logic [N_PORTS-1:0]                           s_rdone,
   input  logic                                         m_wready,
   output logic [ADDR_WIDTH-1:0]                        m_waddr,
   output logic [DATA_WIDTH*BURST_LEN-1:0]              m_wdata,
   output logic [DATA_WIDTH*BURST_LEN/B_WIDTH-1:0]      m_wstrb,
   output logic                                         m_wvalid,
   input  logic                                         m_wdone,
   input  logic                                         m_rready,
   output logic [ADDR_WIDTH-1:0]                        m_raddr,
   output logic                                         m_rvalid,
   input  logic [DATA_WIDTH*BURST_LEN-1:0]              m_rdata,
   input  logic                                         m_rdone
);
   localparam int L  = DATA_WIDTH * BURST_LEN;
   localparam int S  = L / B_WIDTH;
   localparam int WW = ADDR_WIDTH + L + S;
   logic [N_PORTS*WW-1:0] wpay;
   logic [WW-1:0] m_wpay;
   logic rfin, wfin;
   for (genvar i = 0; i < N_PORTS; i++) begin : g_wpay
      assign wpay[i*WW +: WW] = {s_wstrb[i*S +: S], s_wdata[i*L +: L], s_waddr[i*ADDR_WIDTH +: ADDR_WIDTH]};
   end
   assign {m_wstrb, m_wdata, m_waddr} = m_wpay;
   rip_axi_arbiter_chan #(.N(N_PORTS), .W(ADDR_WIDTH)) u_rd (
      .clk(clk), .rst(rst), .s_ready(s_rready), .s_pay(s_raddr), .s_valid(s_rvalid),
      .s_done(s_rdone), .m_ready(m_rready), .m_pay(m_raddr), .m_valid(m_rvalid),
      .m_done(m_rdone), .fin(rfin)
   );
   rip_axi_arbiter_chan #(.N(N_PORTS), .W(WW)) u_wr (
      .clk(clk), .rst(rst), .s_ready(s_wready), .s_pay(wpay), .s_valid(s_wvalid),
      .s_done(s_wdone), .m_ready(m_wready), .m_pay(m_wpay), .m_valid(m_wvalid),
      .m_done(m_wdone), .fin(wfin)
   );
   always_ff @(posedge clk)
      if (rst) s_rdata <= '0;
      else if (rfin) s_rdata <= m_rdata;
endmodule

// File: tb/tb_rip_axi_arbiter.sv
// tb_rip_axi_arbiter: directed scoreboard bench with a behavioural memory behind the master port
module tb_rip_axi_arbiter;
   localparam int N = 2, A = 32, L = 64, S = 8;
   localparam logic [L-1:0] E10 = 64'h1234567890abcdef, E18 = 64'hcdef90ab56781234;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] s_wready, s_wvalid = '0, s_wdone, s_rready, s_rvalid = '0, s_rdone;
   logic [N*A-1:0] s_waddr = '0, s_raddr = '0;
   logic [N*L-1:0] s_wdata = '0;
   logic [N*S-1:0] s_wstrb = '0;
   logic [L-1:0] s_rdata, m_wdata, m_rdata;
   logic [S-1:0] m_wstrb;
   logic [A-1:0] m_waddr, m_raddr;
   logic m_wready, m_wvalid, m_wdone, m_rready, m_rvalid, m_rdone;
   logic [L-1:0] mem [logic [A-1:0]];
   logic rb, wb;
   int rc, wc;
   logic [A-1:0] ra, wa;
   logic [L-1:0] wd, mv;
   logic [S-1:0] ws;
   int checks = 0, errors = 0, rv_cnt = 0, wv_cnt = 0, wd_cnt = 0, wexp = 0, done_p = -1, gnt_cnt = 0;
   int ep [$];
   logic [L-1:0] ed [$];

   always #5 clk = ~clk;

   rip_axi_arbiter dut (
      .clk(clk), .rst(rst), .s_wready(s_wready), .s_waddr(s_waddr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wdone(s_wdone), .s_rready(s_rready),
      .s_raddr(s_raddr), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rdone(s_rdone),
      .m_wready(m_wready), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_wvalid(m_wvalid), .m_wdone(m_wdone), .m_rready(m_rready), .m_raddr(m_raddr),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rdone(m_rdone)
   );

   always @(posedge clk) begin
      if (rst) begin
         rb <= 1'b0; wb <= 1'b0; m_rready <= 1'b1; m_wready <= 1'b1;
         m_rdone <= 1'b0; m_wdone <= 1'b0; m_rdata <= '0;
      end else begin
         m_rdone <= 1'b0;
         m_wdone <= 1'b0;
         if (m_rvalid && m_rready) begin
            rb <= 1'b1; ra <= m_raddr; rc <= 3; m_rready <= 1'b0;
         end else if (rb && rc > 0) rc <= rc - 1;
         else if (rb) begin
            m_rdata <= mem.exists(ra) ? mem[ra] : '0;
            m_rdone <= 1'b1; rb <= 1'b0; m_rready <= 1'b1;
         end
         if (m_wvalid && m_wready) begin
            wb <= 1'b1; wa <= m_waddr; wd <= m_wdata; ws <= m_wstrb; wc <= 2; m_wready <= 1'b0;
         end else if (wb && wc > 0) wc <= wc - 1;
         else if (wb) begin
            mv = mem.exists(wa) ? mem[wa] : '0;
            for (int b = 0; b < S; b++) if (ws[b]) mv[b*8 +: 8] = wd[b*8 +: 8];
            mem[wa] = mv;
            m_wdone <= 1'b1; wb <= 1'b0; m_wready <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      done_p = -1;
      if (m_rvalid) rv_cnt++;
      if (m_wvalid) wv_cnt++;
      wd_cnt += $countones(s_wdone);
      if (s_rdone != '0) begin
         gnt_cnt++;
         if (ep.size() == 0) chk("rdone_spurious", 64'(s_rdone), 64'd0);
         else begin
            done_p = ep.pop_front();
            chk("rdone_port", 64'(s_rdone), 64'd1 << done_p);
            chk("rdata", s_rdata, ed.pop_front());
            chk("ready_in_done", 64'(s_rready[done_p]), 64'd1);
         end
      end
   endtask

   task automatic fire();
      step();
      s_rvalid = '0;
      s_wvalid = '0;
   endtask

   task automatic rd(input int p, input logic [A-1:0] a, input logic [L-1:0] e);
      chk("rready", 64'(s_rready[p]), 64'd1);
      s_rvalid[p] = 1'b1;
      s_raddr[p*A +: A] = a;
      ep.push_back(p);
      ed.push_back(e);
   endtask

   task automatic wr(input int p, input logic [A-1:0] a, input logic [L-1:0] d, input logic [S-1:0] st);
      chk("wready", 64'(s_wready[p]), 64'd1);
      s_wvalid[p] = 1'b1;
      s_waddr[p*A +: A] = a;
      s_wdata[p*L +: L] = d;
      s_wstrb[p*S +: S] = st;
      wexp++;
   endtask

   task automatic drain();
      int b = 0;
      while ((ep.size() != 0 || wd_cnt != wexp) && b < 300) begin
         step();
         b++;
      end
      chk("drain", 64'(ep.size() == 0 && wd_cnt == wexp), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_rvalid = '0;
      s_wvalid = '0;
      step();
      rst = 1'b0;
      ep.delete();
      ed.delete();
      wexp = wd_cnt;
      chk("rst_valid_done", 64'({m_rvalid, m_wvalid, s_rdone, s_wdone}), 64'd0);
      chk("rst_addr", {m_raddr, m_waddr}, 64'd0);
      chk("rst_wdata", m_wdata, 64'd0);
      chk("rst_wstrb", 64'(m_wstrb), 64'd0);
      chk("rst_rdata", s_rdata, 64'd0);
      chk("rst_ready", 64'({s_rready, s_wready}), 64'hf);
   endtask

   initial begin
      int rv0, rem [N];
      do_reset();
      // single read with latency check
      wr(0, 32'h10, 64'h1234, 8'hff);
      fire();
      drain();
      rv0 = rv_cnt;
      rd(0, 32'h10, 64'h1234);
      fire();
      chk("lat_early", 64'(m_rvalid), 64'd0);
      step();
      chk("lat_rvalid", 64'(m_rvalid), 64'd1);
      chk("lat_raddr", 64'(m_raddr), 64'h10);
      drain();
      chk("single_pulses", 64'(rv_cnt - rv0), 64'd1);
      // simultaneous reads
      do_reset();
      wr(0, 32'h10, E10, 8'hff);
      wr(1, 32'h18, E18, 8'hff);
      fire();
      drain();
      rv0 = rv_cnt;
      rd(0, 32'h10, E10);
      rd(1, 32'h18, E18);
      fire();
      drain();
      chk("simul_pulses", 64'(rv_cnt - rv0), 64'd2);
      // fairness with done-cycle re-requests
      do_reset();
      rv0 = gnt_cnt;
      rem[0] = 3;
      rem[1] = 3;
      rd(0, 32'h10, E10);
      rd(1, 32'h18, E18);
      fire();
      for (int b = 0; b < 400 && ep.size() != 0; b++) begin
         step();
         s_rvalid = '0;
         if (done_p >= 0 && rem[done_p] > 0) begin
            rd(done_p, done_p == 1 ? 32'h18 : 32'h10, done_p == 1 ? E18 : E10);
            rem[done_p]--;
         end
      end
      chk("fair_count", 64'(gnt_cnt - rv0), 64'd8);
      // concurrent read and write
      wr(0, 32'h30, 64'hc0ffeeadd1c0ffee, 8'hff);
      fire();
      drain();
      wr(1, 32'h38, 64'h000000000fab1e55, 8'hff);
      rd(0, 32'h30, 64'hc0ffeeadd1c0ffee);
      fire();
      step();
      chk("overlap", 64'({m_wvalid, m_rvalid}), 64'h3);
      drain();
      rd(1, 32'h38, 64'h000000000fab1e55);
      fire();
      drain();
      // strobes
      wr(1, 32'h20, 64'hcafecafecafecafe, 8'hff);
      fire();
      drain();
      wr(1, 32'h20, 64'hbeefbeefbeefbeef, 8'b01100100);
      fire();
      step();
      chk("wstrb_pass", 64'({m_wvalid, m_wstrb}), 64'h164);
      drain();
      rd(0, 32'h20, 64'hcaefbefecaefcafe);
      fire();
      drain();
      // reset while a read is in WAIT
      s_rvalid[1] = 1'b1;
      s_raddr[A +: A] = 32'h18;
      fire();
      step();
      step();
      do_reset();
      rd(0, 32'h10, E10);
      fire();
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
